pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the issue counter.
REQ-002 SHALL have parameter NOWR, default 31, the write-register code meaning "no write".
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 id_valid  in  1  ID holds a real instruction.
REQ-006 id_rs0 / id_rs1  in  4 each  ID source registers.
REQ-007 id_use_rs1  in  1  id_rs1 is a real operand.
REQ-008 id_wr  in  5  ID destination; NOWR means none.
REQ-009 id_write / id_load / id_mem / id_halt  in  1 each  regwrite, load, load-or-store, and halt decode flags from the control unit.
REQ-010 ex_taken  in  1  branch/jump in EX resolved taken.
REQ-011 mem_ready  in  1  data memory completes the MEM-stage access this cycle.
REQ-012 stall_if / stall_id  out  1 each  hold PC / hold the IF-ID register.
REQ-013 bubble_ex  out  1  load a NOP into ID-EX.
REQ-014 flush  out  1  squash IF and ID contents.
REQ-015 freeze  out  1  hold ID-EX, EX-MEM and MEM-WB.
REQ-016 fwd0 / fwd1  out  2 each  operand source: 00 regfile, 01 EX-MEM, 10 MEM-WB, 11 WB bypass.
REQ-017 halted  out  1  machine stopped.
REQ-018 issue_count  out  CNT_W  instructions issued to EX.

Function
REQ-019 SHALL keep shadow slots EX, MEM and WB, each holding {v, wr, wen, ld, mem, halt}; when freeze=0, slots shift EX->MEM->WB every cycle; when freeze=1, all slots hold.
REQ-020 SHALL define issue as: freeze=0, flush=0, stall_id=0 and id_valid=1; on issue, the EX slot SHALL load the ID flags, otherwise it SHALL load v=0.
REQ-021 SHALL define a slot match on rs as: v & wen & (wr!=NOWR) & (wr==rs).
REQ-022 SHALL drive fwd0 by priority: EX non-load match 01, MEM match 10, WB match 11, else 00; fwd1 uses the same rule but is 00 whenever id_use_rs1=0.
REQ-023 SHALL treat a load-use hazard as an EX-slot match with ld=1 on rs0, or on rs1 when id_use_rs1=1, with id_valid=1.
REQ-024 SHALL resolve priority each cycle as freeze > flush > load-use > normal.
REQ-025 freeze SHALL equal MEM.v & MEM.mem & ~mem_ready (combinational); during freeze: stall_if=stall_id=1, bubble_ex=0, flush=0, and ex_taken is ignored.
REQ-026 With ex_taken=1 and freeze=0: flush=1 and bubble_ex=1; stall_if=stall_id=0; load-use is suppressed; nothing issues.
REQ-027 On load-use: stall_if=stall_id=bubble_ex=1 for exactly one cycle; next cycle the load is in MEM and fwd selects 10.
REQ-028 FSM states SHALL be RUN, DRAIN and HALTED.
REQ-029 RUN->DRAIN SHALL occur when an instruction with id_halt issues; a halt squashed by flush SHALL leave the state in RUN.
REQ-030 In DRAIN: stall_if=stall_id=bubble_ex=1; freeze rules still apply.
REQ-031 DRAIN->HALTED SHALL occur when WB.halt=1 and freeze=0.
REQ-032 In HALTED: halted=1, stall_if=stall_id=bubble_ex=1, all slots v=0; only reset exits HALTED.
REQ-033 issue_count SHALL increment by 1 per issue, including halt, and wrap modulo 2^CNT_W.

Reset
REQ-034 On rst_n=0, immediately and regardless of state: state=RUN, all slots v=0, issue_count=0.
REQ-035 While rst_n=0, all outputs SHALL be 0: stall_if, stall_id, bubble_ex, flush, freeze, halted, and fwd0/fwd1=00.
REQ-036 Reset asserted mid-DRAIN or mid-freeze SHALL abort the operation; the first cycle after release is RUN with an empty pipe.

Verification
REQ-037 Load-use: ld wr=2 issues, next ID rs0=2 -> one cycle of stall_id=1 and bubble_ex=1, then fwd0=10; issue_count +2.
REQ-038 ALU forward and NOWR: add wr=1, then rs1=1 with use_rs1=1 -> fwd1=01 with no stall; same with use_rs1=0 -> fwd1=00; wr=31 with rs0 matching the low bits -> fwd0=00.
REQ-039 Branch with pending load-use: ex_taken=1 in the same cycle -> flush=1, bubble_ex=1, stall_id=0, and issue_count unchanged.
REQ-040 Memory wait: store in MEM with mem_ready=0 for 3 cycles -> freeze=1 for exactly 3 cycles; ex_taken pulsed during freeze yields flush=0; slots unchanged.
REQ-041 Halt: halt issues at edge N -> DRAIN; halted=1 after edge N+3; stall_if held at 1 throughout.
REQ-042 Reset mid-DRAIN: rst_n low for 1 cycle -> halted=0, state RUN, issue_count=0, and the next valid instruction issues.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: hazard, forwarding, freeze and halt control for a 5-stage pipeline
module pipeline_sequencer #(
    parameter int CNT_W = 16,
    parameter int NOWR  = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       id_rs0,
    input  logic [3:0]       id_rs1,
    input  logic             id_use_rs1,
    input  logic [4:0]       id_wr,
    input  logic             id_write,
    input  logic             id_load,
    input  logic             id_mem,
    input  logic             id_halt,
    input  logic             ex_taken,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush,
    output logic             freeze,
    output logic [1:0]       fwd0,
    output logic [1:0]       fwd1,
    output logic             halted,
    output logic [CNT_W-1:0] issue_count
);
    typedef struct packed {
        logic       v;
        logic [4:0] wr;
        logic       wen;
        logic       ld;
        logic       mem;
        logic       halt;
    } slot_t;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    localparam logic [4:0] NW = NOWR[4:0];
    state_t state, state_nx;
    slot_t  ex_s, mem_s, wb_s, id_s;
    logic   frz, lu, run, fl, sid, bub, issue;
    function automatic logic hit(slot_t s, logic [3:0] rs);
        return s.v & s.wen & (s.wr != NW) & (s.wr == {1'b0, rs});
    endfunction
    function automatic logic [1:0] src(slot_t e, slot_t m, slot_t w, logic [3:0] rs);
        return (hit(e, rs) & ~e.ld) ? 2'b01 : hit(m, rs) ? 2'b10 : hit(w, rs) ? 2'b11 : 2'b00;
    endfunction
    assign id_s = {1'b1, id_wr, id_write, id_load, id_mem, id_halt};
    // Resolve freeze > flush > load-use > normal and the halt-drain FSM transitions
    always_comb begin
        state_nx = state;
        run      = state == RUN;
        frz      = mem_s.v & mem_s.mem & ~mem_ready;
        lu       = id_valid & ex_s.ld & (hit(ex_s, id_rs0) | (id_use_rs1 & hit(ex_s, id_rs1)));
        fl       = run & ~frz & ex_taken;
        sid      = frz | ~run | (~fl & lu);
        bub      = ~frz & (~run | fl | lu);
        issue    = run & ~frz & ~fl & ~lu & id_valid;
        if (issue & id_halt)
            state_nx = DRAIN;
        if (state == DRAIN & wb_s.v & wb_s.halt & ~frz)
            state_nx = HALTED;
    end
    assign stall_if  = rst_n & sid;
    assign stall_id  = rst_n & sid;
    assign bubble_ex = rst_n & bub;
    assign flush     = rst_n & fl;
    assign freeze    = rst_n & frz;
    assign halted    = rst_n & (state == HALTED);
    assign fwd0      = rst_n ? src(ex_s, mem_s, wb_s, id_rs0) : 2'b00;
    assign fwd1      = (rst_n & id_use_rs1) ? src(ex_s, mem_s, wb_s, id_rs1) : 2'b00;
    // State, shadow slots and issue counter; slots hold while frozen and stay empty once halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            ex_s        <= '0;
            mem_s       <= '0;
            wb_s        <= '0;
            issue_count <= '0;
        end else begin
            state <= state_nx;
            if (state == HALTED) begin
                ex_s  <= '0;
                mem_s <= '0;
                wb_s  <= '0;
            end else if (!frz) begin
                ex_s  <= issue ? id_s : '0;
                mem_s <= ex_s;
                wb_s  <= mem_s;
            end
            if (issue)
                issue_count <= issue_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed vectors, halt/reset sequences and randomized model comparison
module tb_pipeline_sequencer;
    logic        clk = 0, rst_n = 0;
    logic        id_valid = 0, id_use_rs1 = 0, id_write = 0, id_load = 0, id_mem = 0, id_halt = 0;
    logic        ex_taken = 0, mem_ready = 1;
    logic [3:0]  id_rs0 = 0, id_rs1 = 0;
    logic [4:0]  id_wr = 31;
    logic        stall_if, stall_id, bubble_ex, flush, freeze, halted;
    logic [1:0]  fwd0, fwd1;
    logic [15:0] issue_count;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    pipeline_sequencer dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs0(id_rs0), .id_rs1(id_rs1),
        .id_use_rs1(id_use_rs1), .id_wr(id_wr), .id_write(id_write), .id_load(id_load),
        .id_mem(id_mem), .id_halt(id_halt), .ex_taken(ex_taken), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush(flush),
        .freeze(freeze), .fwd0(fwd0), .fwd1(fwd1), .halted(halted), .issue_count(issue_count)
    );

    typedef struct {
        logic valid; logic [3:0] rs0, rs1; logic use1; logic [4:0] wr;
        logic wen, ld, mem, halt, taken, ready;
        logic stall, bub, flush, frz; logic [1:0] f0, f1; int cnt;
    } vec_t;
    vec_t tbl[19];

    typedef struct { logic [4:0] wr; logic wen, ld, mem, halt; int age; } ins_t;
    ins_t        q[$];
    bit          m_drain, m_halted, m_z, m_iss;
    logic [15:0] m_cnt;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", n, a, e, $time);
        end
    endtask

    task automatic cmp_all(string t, logic s, logic b, logic f, logic z, logic h,
                           logic [1:0] f0, logic [1:0] f1, logic [15:0] c);
        chk({t, ".stall_if"}, 32'(stall_if), 32'(s));
        chk({t, ".stall_id"}, 32'(stall_id), 32'(s));
        chk({t, ".bubble_ex"}, 32'(bubble_ex), 32'(b));
        chk({t, ".flush"}, 32'(flush), 32'(f));
        chk({t, ".freeze"}, 32'(freeze), 32'(z));
        chk({t, ".halted"}, 32'(halted), 32'(h));
        chk({t, ".fwd0"}, 32'(fwd0), 32'(f0));
        chk({t, ".fwd1"}, 32'(fwd1), 32'(f1));
        chk({t, ".issue_count"}, 32'(issue_count), 32'(c));
    endtask

    function automatic logic hit(logic [4:0] wr, logic wen, logic [3:0] rs);
        return wen && wr != 5'd31 && wr == {1'b0, rs};
    endfunction

    // youngest producer wins; a load still in EX cannot forward, and the code is the producer's age
    function automatic logic [1:0] src(logic [3:0] rs);
        for (int a = 1; a <= 3; a++)
            foreach (q[i])
                if (q[i].age == a && hit(q[i].wr, q[i].wen, rs) && !(a == 1 && q[i].ld))
                    return 2'(a);
        return 2'b00;
    endfunction

    function automatic logic m_frz();
        foreach (q[i]) if (q[i].age == 2 && q[i].mem && !mem_ready) return 1;
        return 0;
    endfunction

    function automatic logic m_lu();
        if (!id_valid) return 0;
        foreach (q[i])
            if (q[i].age == 1 && q[i].ld &&
                (hit(q[i].wr, q[i].wen, id_rs0) || (id_use_rs1 && hit(q[i].wr, q[i].wen, id_rs1))))
                return 1;
        return 0;
    endfunction

    task automatic model_check();
        logic z, lu, busy;
        z = m_frz(); lu = m_lu(); busy = m_drain || m_halted;
        cmp_all("rnd", z || busy || (!ex_taken && lu), !z && (busy || ex_taken || lu),
                !z && !busy && ex_taken, z, m_halted, src(id_rs0),
                id_use_rs1 ? src(id_rs1) : 2'b00, m_cnt);
        m_z   = z;
        m_iss = !z && !busy && !ex_taken && !lu && id_valid;
    endtask

    task automatic model_step();
        ins_t n[$];
        if (m_drain && !m_z)
            foreach (q[i]) if (q[i].age == 3 && q[i].halt) begin m_drain = 0; m_halted = 1; end
        if (!m_z) begin
            foreach (q[i]) if (q[i].age < 3) begin q[i].age++; n.push_back(q[i]); end
            q = n;
        end
        if (m_iss) begin
            q.push_back('{id_wr, id_write, id_load, id_mem, id_halt, 1});
            m_cnt++;
            if (id_halt) m_drain = 1;
        end
        if (m_halted) q.delete();
    endtask

    task automatic do_reset();
        rst_n = 0; ex_taken = 1; id_valid = 1; id_halt = 0;
        #1 cmp_all("rst", 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        @(posedge clk); #1;
        rst_n = 1; ex_taken = 0; id_valid = 0;
        q.delete(); m_drain = 0; m_halted = 0; m_cnt = 0;
    endtask

    task automatic drive(vec_t v);
        id_valid = v.valid; id_rs0 = v.rs0; id_rs1 = v.rs1; id_use_rs1 = v.use1; id_wr = v.wr;
        id_write = v.wen; id_load = v.ld; id_mem = v.mem; id_halt = v.halt;
        ex_taken = v.taken; mem_ready = v.ready;
    endtask

    initial begin
        tbl[0]  = '{1,  0, 0, 0,  2, 1, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1,  2, 0, 0,  3, 1, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 1};
        tbl[2]  = '{1,  2, 0, 0,  3, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2, 0, 1};
        tbl[3]  = '{1,  5, 3, 1,  4, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 2};
        tbl[4]  = '{1,  0, 4, 0, 31, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 3};
        tbl[5]  = '{1, 15, 3, 1,  6, 1, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 3, 4};
        tbl[6]  = '{1,  6, 0, 0,  7, 1, 0, 0, 0, 1, 1,  0, 1, 1, 0, 0, 0, 5};
        tbl[7]  = '{1,  6, 0, 0,  7, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 2, 0, 5};
        tbl[8]  = '{1,  6, 0, 0,  7, 1, 0, 0, 0, 1, 0,  1, 0, 0, 1, 2, 0, 5};
        tbl[9]  = '{1,  6, 0, 0,  7, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 2, 0, 5};
        tbl[10] = '{1,  6, 0, 0,  7, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2, 0, 5};
        tbl[11] = '{0,  6, 0, 0,  7, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 3, 0, 6};
        tbl[12] = '{0,  7, 0, 0,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2, 0, 6};
        tbl[13] = '{1,  0, 0, 0, 31, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 6};
        tbl[14] = '{0,  0, 0, 0, 31, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 7};
        tbl[15] = '{0,  0, 0, 0, 31, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 7};
        tbl[16] = '{0,  0, 0, 0, 31, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 7};
        tbl[17] = '{0,  0, 0, 0, 31, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 7};
        tbl[18] = '{0,  0, 0, 0, 31, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 7};
        #2 do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #2 cmp_all($sformatf("vec%0d", i), tbl[i].stall, tbl[i].bub, tbl[i].flush,
                       tbl[i].frz, 0, tbl[i].f0, tbl[i].f1, 16'(tbl[i].cnt));
            @(posedge clk); #1;
        end
        id_valid = 1; id_halt = 1; id_wr = 31; id_write = 0; id_load = 0; id_mem = 0;
        id_use_rs1 = 0; ex_taken = 0; mem_ready = 1;
        #2 chk("halt.pre_stall", 32'(stall_if), 0);
        @(posedge clk); #1;
        id_halt = 0;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("halt.n%0d.stall_if", k), 32'(stall_if), 1);
            chk($sformatf("halt.n%0d.bubble", k), 32'(bubble_ex), 1);
            chk($sformatf("halt.n%0d.halted", k), 32'(halted), 0);
            chk($sformatf("halt.n%0d.count", k), 32'(issue_count), 8);
            @(posedge clk); #1;
        end
        chk("halt.n4.halted", 32'(halted), 1);
        chk("halt.n4.stall_if", 32'(stall_if), 1);
        chk("halt.n4.count", 32'(issue_count), 8);
        do_reset();
        id_valid = 1; id_halt = 1;
        @(posedge clk); #1;
        id_halt = 0;
        chk("drain.stall_if", 32'(stall_if), 1);
        chk("drain.count", 32'(issue_count), 1);
        #1 rst_n = 0; ex_taken = 1;
        #1 cmp_all("drain_rst", 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        @(posedge clk); #1;
        rst_n = 1; ex_taken = 0;
        chk("post_rst.halted", 32'(halted), 0);
        chk("post_rst.stall_if", 32'(stall_if), 0);
        chk("post_rst.count", 32'(issue_count), 0);
        @(posedge clk); #1;
        chk("post_rst.issue", 32'(issue_count), 1);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            id_valid   = $urandom_range(0, 3) != 0;
            id_rs0     = 4'($urandom_range(0, 3));
            id_rs1     = 4'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_wr      = ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3));
            id_write   = $urandom_range(0, 3) != 0;
            id_load    = $urandom_range(0, 2) == 0;
            id_mem     = id_load || $urandom_range(0, 4) == 0;
            id_halt    = $urandom_range(0, 39) == 0;
            ex_taken   = $urandom_range(0, 7) == 0;
            mem_ready  = $urandom_range(0, 3) != 0;
            #2 model_check();
            @(posedge clk);
            model_step();
            #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
